// File: rtl/interrupt_sequencer.sv
// Opcode/BRK substitution at T0 and the 7-cycle BRK/IRQ/NMI/RESET sequence
// that drives vector selection, push suppression and flag control for the core.
module interrupt_sequencer #(
    parameter logic [15:0] VEC_NMI = 16'hFFFA,
    parameter logic [15:0] VEC_RST = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ = 16'hFFFE
) (
    input  logic        sys_clock,
    input  logic        rst,
    input  logic        clk_ph1,
    input  logic        sync,
    input  logic        int_in,
    input  logic        nmi_in,
    input  logic [7:0]  data_in,
    output logic [7:0]  ir_out,
    output logic        seq_active,
    output logic [2:0]  seq_step,
    output logic [15:0] vec_addr,
    output logic        pc_inc_inhibit,
    output logic        write_inhibit,
    output logic        b_flag,
    output logic        set_i,
    output logic        int_clr,
    output logic        nmi_clr
);

    typedef enum logic [1:0] {
        KIND_RESET = 2'd0,
        KIND_NMI   = 2'd1,
        KIND_IRQ   = 2'd2,
        KIND_BRK   = 2'd3
    } kind_t;

    function automatic logic [15:0] vector_for(input kind_t k);
        case (k)
            KIND_NMI:   vector_for = VEC_NMI;
            KIND_RESET: vector_for = VEC_RST;
            default:    vector_for = VEC_IRQ;
        endcase
    endfunction

    logic [7:0]  ir_r;
    logic [2:0]  step_r;
    logic        seq_active_r;
    logic [15:0] vec_addr_r;
    logic        pc_inc_inhibit_r;
    logic        write_inhibit_r;
    logic        b_flag_r;
    logic        set_i_r;
    logic        int_clr_r;
    logic        nmi_clr_r;
    logic        reset_pending_r;
    kind_t       kind_r;

    logic        start_s;
    logic        hijack_s;
    kind_t       next_kind_s;

    // Decide at T0 whether a sequence starts and which kind it is
    always_comb begin
        start_s     = 1'b0;
        next_kind_s = kind_r;
        if (sync && int_in) begin
            start_s = 1'b1;
            if (reset_pending_r) begin
                next_kind_s = KIND_RESET;
            end else if (nmi_in) begin
                next_kind_s = KIND_NMI;
            end else begin
                next_kind_s = KIND_IRQ;
            end
        end else if (sync && (data_in == 8'h00)) begin
            start_s     = 1'b1;
            next_kind_s = KIND_BRK;
        end else begin
            start_s     = 1'b0;
            next_kind_s = kind_r;
        end
        hijack_s = nmi_in && ((kind_r == KIND_IRQ) || (kind_r == KIND_BRK));
    end

    // Sequencer state and registered outputs; pulses drop on non-Phi1 edges
    always_ff @(posedge sys_clock or negedge rst) begin
        if (!rst) begin
            ir_r             <= 8'h00;
            step_r           <= 3'd0;
            seq_active_r     <= 1'b0;
            vec_addr_r       <= VEC_RST;
            pc_inc_inhibit_r <= 1'b0;
            write_inhibit_r  <= 1'b0;
            b_flag_r         <= 1'b0;
            set_i_r          <= 1'b0;
            int_clr_r        <= 1'b0;
            nmi_clr_r        <= 1'b0;
            reset_pending_r  <= 1'b1;
            kind_r           <= KIND_RESET;
        end else if (!clk_ph1) begin
            set_i_r   <= 1'b0;
            int_clr_r <= 1'b0;
            nmi_clr_r <= 1'b0;
        end else begin
            set_i_r   <= 1'b0;
            int_clr_r <= 1'b0;
            nmi_clr_r <= 1'b0;
            case (step_r)
                // Step 6 exits through the idle decision so back-to-back sequences work
                3'd0, 3'd6: begin
                    if (start_s) begin
                        step_r           <= 3'd1;
                        seq_active_r     <= 1'b1;
                        ir_r             <= 8'h00;
                        kind_r           <= next_kind_s;
                        pc_inc_inhibit_r <= int_in;
                    end else begin
                        step_r           <= 3'd0;
                        seq_active_r     <= 1'b0;
                        pc_inc_inhibit_r <= 1'b0;
                        if (sync) begin
                            ir_r <= data_in;
                        end
                    end
                end
                3'd1, 3'd2: begin
                    step_r          <= step_r + 3'd1;
                    write_inhibit_r <= (kind_r == KIND_RESET);
                end
                3'd3: begin
                    step_r          <= 3'd4;
                    write_inhibit_r <= (kind_r == KIND_RESET);
                    b_flag_r        <= (kind_r == KIND_BRK);
                    if (hijack_s) begin
                        kind_r <= KIND_NMI;
                    end
                end
                3'd4: begin
                    step_r          <= 3'd5;
                    write_inhibit_r <= 1'b0;
                    b_flag_r        <= 1'b0;
                    vec_addr_r      <= vector_for(kind_r);
                    set_i_r         <= 1'b1;
                    nmi_clr_r       <= (kind_r == KIND_NMI);
                end
                3'd5: begin
                    step_r          <= 3'd6;
                    int_clr_r       <= 1'b1;
                    reset_pending_r <= 1'b0;
                end
                default: begin
                    step_r           <= 3'd0;
                    seq_active_r     <= 1'b0;
                    pc_inc_inhibit_r <= 1'b0;
                    write_inhibit_r  <= 1'b0;
                    b_flag_r         <= 1'b0;
                end
            endcase
        end
    end

    assign ir_out         = ir_r;
    assign seq_step       = step_r;
    assign seq_active     = seq_active_r;
    assign vec_addr       = vec_addr_r;
    assign pc_inc_inhibit = pc_inc_inhibit_r;
    assign write_inhibit  = write_inhibit_r;
    assign b_flag         = b_flag_r;
    assign set_i          = set_i_r;
    assign int_clr        = int_clr_r;
    assign nmi_clr        = nmi_clr_r;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: step-table model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_interrupt_sequencer;

    logic        sys_clock;
    logic        rst;
    logic        clk_ph1;
    logic        sync;
    logic        int_in;
    logic        nmi_in;
    logic [7:0]  data_in;
    logic [7:0]  ir_out;
    logic        seq_active;
    logic [2:0]  seq_step;
    logic [15:0] vec_addr;
    logic        pc_inc_inhibit;
    logic        write_inhibit;
    logic        b_flag;
    logic        set_i;
    logic        int_clr;
    logic        nmi_clr;

    interrupt_sequencer dut (
        .sys_clock      (sys_clock),
        .rst            (rst),
        .clk_ph1        (clk_ph1),
        .sync           (sync),
        .int_in         (int_in),
        .nmi_in         (nmi_in),
        .data_in        (data_in),
        .ir_out         (ir_out),
        .seq_active     (seq_active),
        .seq_step       (seq_step),
        .vec_addr       (vec_addr),
        .pc_inc_inhibit (pc_inc_inhibit),
        .write_inhibit  (write_inhibit),
        .b_flag         (b_flag),
        .set_i          (set_i),
        .int_clr        (int_clr),
        .nmi_clr        (nmi_clr)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    localparam int K_RST = 0;
    localparam int K_NMI = 1;
    localparam int K_IRQ = 2;
    localparam int K_BRK = 3;

    int n_vec = 0;
    int n_err = 0;

    // Model state: where in the 7-cycle table we are and what kind is running
    int          m_step;
    int          m_kind;
    bit          m_brk;
    bit          m_rp;
    bit          m_pci;
    bit          m_last_ph;
    logic [7:0]  m_ir;
    logic [15:0] m_vec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_vec(input int k);
        if (k == K_NMI) return 16'hFFFA;
        if (k == K_RST) return 16'hFFFC;
        return 16'hFFFE;
    endfunction

    task automatic model_reset();
        m_step = 0; m_kind = K_RST; m_brk = 1'b0; m_rp = 1'b1; m_pci = 1'b0;
        m_last_ph = 1'b0; m_ir = 8'h00; m_vec = 16'hFFFC;
    endtask

    task automatic model_update();
        if (!rst) return;
        m_last_ph = clk_ph1;
        if (!clk_ph1) return;
        if (m_step == 0 || m_step == 6) begin
            m_step = 0;
            m_pci  = 1'b0;
            if (sync && int_in) begin
                m_ir = 8'h00; m_step = 1; m_pci = 1'b1; m_brk = 1'b0;
                m_kind = m_rp ? K_RST : (nmi_in ? K_NMI : K_IRQ);
            end else if (sync && data_in == 8'h00) begin
                m_ir = 8'h00; m_step = 1; m_pci = 1'b0; m_brk = 1'b1; m_kind = K_BRK;
            end else if (sync) begin
                m_ir = data_in;
            end
        end else begin
            if (m_step == 3 && nmi_in && (m_kind == K_IRQ || m_kind == K_BRK)) m_kind = K_NMI;
            m_step = m_step + 1;
            if (m_step == 5) m_vec = model_vec(m_kind);
            if (m_step == 6) m_rp = 1'b0;
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge sys_clock);
        @(negedge sys_clock);
        #1;
    endtask

    // Every-cycle comparison of all outputs against the step table
    always @(negedge sys_clock) begin
        chk("ir_out", ir_out, m_ir);
        chk("seq_step", seq_step, m_step);
        chk("seq_active", seq_active, m_step != 0);
        chk("vec_addr", vec_addr, m_vec);
        chk("pc_inc_inhibit", pc_inc_inhibit, m_pci);
        chk("write_inhibit", write_inhibit, (m_step >= 2 && m_step <= 4 && m_kind == K_RST));
        chk("b_flag", b_flag, (m_step == 4 && m_brk));
        chk("set_i", set_i, (m_last_ph && m_step == 5));
        chk("nmi_clr", nmi_clr, (m_last_ph && m_step == 5 && m_kind == K_NMI));
        chk("int_clr", int_clr, (m_last_ph && m_step == 6));
    end

    initial begin
        rst = 1'b0; clk_ph1 = 1'b1; sync = 1'b0; int_in = 1'b0; nmi_in = 1'b0; data_in = 8'h00;
        model_reset();
        repeat (2) @(negedge sys_clock);
        #1;
        chk("rst_ir", ir_out, 8'h00);
        chk("rst_vec", vec_addr, 16'hFFFC);
        chk("rst_step", seq_step, 3'd0);
        rst = 1'b1;

        // First sync after reset runs the RESET sequence
        int_in = 1'b1; sync = 1'b1; tick();
        chk("reset_ir", ir_out, 8'h00);
        chk("reset_pci", pc_inc_inhibit, 1'b1);
        sync = 1'b0; tick();
        chk("reset_wi_s2", write_inhibit, 1'b1);
        tick(); tick();
        chk("reset_wi_s4", write_inhibit, 1'b1);
        tick();
        chk("reset_vec", vec_addr, 16'hFFFC);
        chk("reset_set_i", set_i, 1'b1);
        chk("reset_nmi_clr", nmi_clr, 1'b0);
        tick();
        chk("reset_int_clr", int_clr, 1'b1);
        int_in = 1'b0; tick();
        chk("reset_done_pci", pc_inc_inhibit, 1'b0);

        // IRQ; sync and data held during the steps are ignored
        int_in = 1'b1; sync = 1'b1; tick();
        chk("irq_pci", pc_inc_inhibit, 1'b1);
        int_in = 1'b0; data_in = 8'hA9;
        tick(); tick(); tick();
        chk("irq_b_flag", b_flag, 1'b0);
        chk("irq_wi", write_inhibit, 1'b0);
        tick();
        chk("irq_vec", vec_addr, 16'hFFFE);
        tick();
        chk("irq_ir_hold", ir_out, 8'h00);
        tick();
        chk("exit_sync_ir", ir_out, 8'hA9);
        chk("exit_sync_active", seq_active, 1'b0);
        sync = 1'b0; tick();

        // NMI
        int_in = 1'b1; nmi_in = 1'b1; sync = 1'b1; tick();
        sync = 1'b0; int_in = 1'b0;
        repeat (4) tick();
        chk("nmi_vec", vec_addr, 16'hFFFA);
        chk("nmi_clr_pulse", nmi_clr, 1'b1);
        chk("nmi_set_i", set_i, 1'b1);
        nmi_in = 1'b0; tick(); tick();

        // BRK
        data_in = 8'h00; sync = 1'b1; tick();
        chk("brk_pci", pc_inc_inhibit, 1'b0);
        sync = 1'b0; data_in = 8'hEA;
        tick(); tick(); tick();
        chk("brk_b_flag", b_flag, 1'b1);
        tick();
        chk("brk_vec", vec_addr, 16'hFFFE);
        tick(); tick();

        // BRK hijacked by NMI rising at step 3, then a back-to-back IRQ
        data_in = 8'h00; sync = 1'b1; tick();
        sync = 1'b0; data_in = 8'hEA; tick(); tick();
        nmi_in = 1'b1; tick();
        chk("hijack_b_flag", b_flag, 1'b1);
        tick();
        chk("hijack_vec", vec_addr, 16'hFFFA);
        chk("hijack_nmi_clr", nmi_clr, 1'b1);
        chk("hijack_pci", pc_inc_inhibit, 1'b0);
        nmi_in = 1'b0; tick();
        sync = 1'b1; int_in = 1'b1; tick();
        chk("b2b_step", seq_step, 3'd1);
        chk("b2b_pci", pc_inc_inhibit, 1'b1);
        sync = 1'b0; int_in = 1'b0;

        // NMI arriving at step 4 is too late; Phi1 gap freezes the sequence
        tick(); tick(); tick();
        nmi_in = 1'b1; tick();
        chk("late_nmi_vec", vec_addr, 16'hFFFE);
        chk("late_nmi_clr", nmi_clr, 1'b0);
        clk_ph1 = 1'b0; tick();
        chk("ph1_hold_step", seq_step, 3'd5);
        chk("ph1_set_i_low", set_i, 1'b0);
        tick();
        clk_ph1 = 1'b1; tick();
        chk("ph1_int_clr", int_clr, 1'b1);
        tick();
        nmi_in = 1'b0;

        // Plain opcode passes through
        data_in = 8'h4C; sync = 1'b1; tick();
        chk("opcode_ir", ir_out, 8'h4C);
        chk("opcode_active", seq_active, 1'b0);
        sync = 1'b0; tick();

        // Asynchronous reset at step 3 of an IRQ, then RESET runs again
        int_in = 1'b1; sync = 1'b1; tick();
        sync = 1'b0; int_in = 1'b0; tick(); tick();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("abort_step", seq_step, 3'd0);
        chk("abort_active", seq_active, 1'b0);
        chk("abort_pci", pc_inc_inhibit, 1'b0);
        chk("abort_vec", vec_addr, 16'hFFFC);
        tick();
        rst = 1'b1;
        int_in = 1'b1; sync = 1'b1; tick();
        sync = 1'b0; int_in = 1'b0;
        tick();
        chk("rerst_wi", write_inhibit, 1'b1);
        repeat (3) tick();
        chk("rerst_vec", vec_addr, 16'hFFFC);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
Downstream consumer of the interrupt controller's perform-interrupt, NMI-pending and IRQ-pending flags. At each opcode fetch it either passes the fetched opcode to the IR or substitutes BRK (0x00). It then steps the 7-cycle BRK/IRQ/NMI/RESET sequence and supplies the CPU core with:
- the vector address
- push/write suppression
- B-flag and I-flag control
- the int_clr and nmi_clr pulses fed back to the controller

Sits between the data-bus latch and the instruction register, beside the CPU cycle decoder.

Parameters:
VEC_NMI, 16'hFFFA, NMI vector low-byte address
VEC_RST, 16'hFFFC, reset vector low-byte address
VEC_IRQ, 16'hFFFE, IRQ/BRK vector low-byte address

Ports:
sys_clock  in  1  main system clock; all state changes on its rising edge
rst  in  1  asynchronous, active-low reset
clk_ph1  in  1  Phi1 enable; the sequencer advances only on edges where this is high
sync  in  1  high during the Phi1 that begins an opcode-fetch cycle (T0)
int_in  in  1  perform-interrupt flag from the interrupt controller
nmi_in  in  1  NMI-pending flag from the interrupt controller
data_in  in  8  fetched opcode from the data-bus latch
ir_out  out  8  opcode presented to the instruction register
seq_active  out  1  high while steps 1..6 run
seq_step  out  3  current sequence step (0 = idle)
vec_addr  out  16  vector low-byte address; the core adds 1 for the high byte
pc_inc_inhibit  out  1  suppresses PC increment for hardware interrupts
write_inhibit  out  1  converts stack pushes into reads (RESET only)
b_flag  out  1  B bit value for the pushed status byte
set_i  out  1  one-cycle pulse that sets the I flag
int_clr  out  1  one-cycle pulse that clears the controller's perform-interrupt flag
nmi_clr  out  1  one-cycle pulse that clears the controller's NMI-pending flag

Behaviour:
- "Cycle" means one sys_clock edge with clk_ph1=1. With clk_ph1=0, all registers hold and all pulse outputs are 0.

Reset (rst=0, asynchronous):
- ir_out=8'h00, seq_step=0, seq_active=0, vec_addr=VEC_RST.
- pc_inc_inhibit, write_inhibit, b_flag, set_i, int_clr and nmi_clr all 0.
- Internal reset_pending=1, kind=RESET.
- rst asserted mid-sequence aborts immediately to these values.

Idle, on a cycle with sync=1:
- int_in=1:
  - ir_out=8'h00, seq_step=1, pc_inc_inhibit=1.
  - kind = RESET if reset_pending, else NMI if nmi_in, else IRQ.
- int_in=0 and data_in=8'h00:
  - ir_out=8'h00, kind=BRK, seq_step=1, pc_inc_inhibit=0.
- Otherwise ir_out=data_in and the block stays idle.

Sequence (seq_step advances by 1 each cycle, 1→6, then returns to 0):
- Steps 1..6: seq_active=1.
- Steps 2..4: write_inhibit = (kind==RESET).
- Step 4: b_flag = (kind==BRK); otherwise b_flag=0.
- Entering step 4, NMI hijack: if nmi_in=1 and kind is IRQ or BRK, kind becomes NMI.
  - b_flag keeps the BRK value.
  - After hijack, a BRK's pc_inc_inhibit stays 0.
- Entering step 5:
  - vec_addr = VEC_NMI / VEC_RST / VEC_IRQ according to kind.
  - set_i pulses.
  - nmi_clr pulses if kind==NMI.
- vec_addr holds its value until the next step 5.
- Entering step 6: int_clr pulses for every kind; reset_pending clears.
- Exit to 0: pc_inc_inhibit clears.

Boundary rules:
- sync, int_in and data_in are ignored during steps 1..6.
- A sync arriving on the exit cycle is evaluated, so back-to-back interrupts are allowed.
- An NMI arriving after step 4 is not hijacked; it stays pending in the controller.

Latency:
- Opcode substitution is visible on ir_out 1 cycle after sync.
- Vector is valid 5 cycles after sync.

Test Plan:
- Release rst with int_in=1 → on the first sync: ir_out=00, kind RESET; write_inhibit=1 at steps 2-4; vec_addr=FFFC at step 5; int_clr pulses at step 6; nmi_clr never pulses.
- Idle, int_in=1, nmi_in=0 at sync → pc_inc_inhibit=1; b_flag=0 at step 4; vec_addr=FFFE; set_i at step 5; int_clr at step 6; write_inhibit stays 0.
- int_in=1, nmi_in=1 at sync → vec_addr=FFFA; nmi_clr and set_i pulse together at step 5.
- data_in=00, int_in=0 → BRK: pc_inc_inhibit=0; b_flag=1 at step 4; vec_addr=FFFE. Repeat with nmi_in rising at step 3 → vec_addr=FFFA, b_flag=1, nmi_clr pulses.
- data_in=A9 at sync, int_in=0 → ir_out=A9 next cycle; seq_active remains 0; no pulses.
- Assert rst at step 3 of an IRQ sequence → all outputs at reset values without a clock edge. Next sequence is RESET with vec_addr=FFFC.
